// File: rtl/axi2sreg_mc.sv
// Memory-mapped control/status register block for a multi-channel AXI stream engine.
// Holds timing shadows that commit to active outputs on frame_sync, plus per-channel setup.
module axi2sreg_mc #(
  parameter logic [17:0] BASE = 18'h0,
  parameter int          NCH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              wen_i,
  input  logic [17:0]       addr_i,
  input  logic [31:0]       din_i,
  output logic [31:0]       dout_o,
  output logic              dout_vld_o,
  input  logic              frame_sync_i,
  input  logic [NCH-1:0]    ierr_i,
  input  logic [NCH-1:0]    oerr_i,
  input  logic [18*NCH-1:0] iacnt_i,
  input  logic [18*NCH-1:0] oacnt_i,
  output logic [NCH-1:0]    ien_o,
  output logic [NCH-1:0]    oen_o,
  output logic [32*NCH-1:0] ibase_o,
  output logic [32*NCH-1:0] obase_o,
  output logic [18*NCH-1:0] isize_o,
  output logic [18*NCH-1:0] osize_o,
  output logic              tddmode_o,
  output logic              test_o,
  output logic [23:0]       frame_len_o,
  output logic [23:0]       tstart_o,
  output logic [23:0]       tend_o,
  output logic [23:0]       rstart_o,
  output logic [23:0]       rend_o,
  output logic [23:0]       frame_adj_o,
  output logic              adj_valid_o,
  output logic              adj_pending_o,
  output logic              commit_pending_o,
  output logic              irq_o
);

  localparam logic [7:0] A_CTRL = 8'h00, A_COMMIT = 8'h04, A_IRQ_STAT = 8'h08,
                         A_IRQ_MASK = 8'h0C, A_FRAME_CNT = 8'h10, A_FRAME_LEN = 8'h20,
                         A_FRAME_ADJ = 8'h24, A_TSTART = 8'h30, A_TEND = 8'h34,
                         A_RSTART = 8'h38, A_REND = 8'h3C;
  localparam logic [4:0] R_EN = 5'h00, R_IBASE = 5'h04, R_ISIZE = 5'h08, R_OBASE = 5'h0C,
                         R_OSIZE = 5'h10, R_IACNT = 5'h14, R_OACNT = 5'h18;
  localparam logic [23:0] LEN_RST = 24'd1920;
  localparam logic [23:0] END_RST = 24'd1919;

  logic        tddmode_q, test_q;
  logic        commit_pending_q, commit_pending_d;
  logic        adj_pending_q, adj_pending_d, adj_valid_q;
  logic [8:0]  irq_stat_q, irq_stat_d, irq_mask_q, irq_set, irq_clr;
  logic        irq_q;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [23:0] sh_len_q, sh_tstart_q, sh_tend_q, sh_rstart_q, sh_rend_q;
  logic [23:0] frame_len_q, tstart_q, tend_q, rstart_q, rend_q, frame_adj_q;
  logic        ien_q [NCH];
  logic        oen_q [NCH];
  logic [31:0] ibase_q [NCH];
  logic [31:0] obase_q [NCH];
  logic [17:0] isize_q [NCH];
  logic [17:0] osize_q [NCH];
  logic [31:0] dout_q;
  logic        dout_vld_q;

  logic        hit, wr, rd, ch_ok, commit_fire, adj_wr, adj_fire;
  logic [7:0]  off;
  logic [2:0]  ch_blk;
  logic [1:0]  ch_idx;
  logic [4:0]  ch_reg;
  logic [31:0] rd_data;

  assign hit    = (addr_i[17:8] == BASE[17:8]);
  assign wr     = en_i & wen_i & hit;
  assign rd     = en_i & ~wen_i & hit;
  assign off    = addr_i[7:0];
  assign ch_blk = off[7:5];
  assign ch_reg = off[4:0];
  assign ch_idx = 2'(ch_blk - 3'd2);
  assign ch_ok  = (ch_blk >= 3'd2) && ((int'(ch_blk) - 2) < NCH);

  // A commit only fires when it was armed before this frame_sync.
  assign commit_fire      = frame_sync_i & commit_pending_q;
  assign commit_pending_d = (wr && off == A_COMMIT && din_i[0]) | (commit_pending_q & ~commit_fire);
  assign adj_wr           = wr && off == A_FRAME_ADJ;
  assign adj_fire         = frame_sync_i & adj_pending_q & ~adj_wr;
  assign adj_pending_d    = adj_wr | (adj_pending_q & ~adj_fire);
  assign frame_cnt_d      = frame_sync_i ? frame_cnt_q + 32'd1 : frame_cnt_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    irq_set             = '0;
    irq_set[NCH-1:0]    = ierr_i;
    irq_set[4 +: NCH]   = oerr_i;
    irq_set[8]          = commit_fire;
    irq_clr             = (wr && off == A_IRQ_STAT) ? din_i[8:0] : 9'h0;
    irq_stat_d          = (irq_stat_q & ~irq_clr) | irq_set;
  end

  always_comb begin
    rd_data = '0;
    case (off)
      A_CTRL:      rd_data = {30'b0, test_q, tddmode_q};
      A_COMMIT:    rd_data = {30'b0, adj_pending_q, commit_pending_q};
      A_IRQ_STAT:  rd_data = {23'b0, irq_stat_q};
      A_IRQ_MASK:  rd_data = {23'b0, irq_mask_q};
      A_FRAME_CNT: rd_data = frame_cnt_q;
      A_FRAME_LEN: rd_data = {8'b0, sh_len_q};
      A_FRAME_ADJ: rd_data = {8'b0, frame_adj_q};
      A_TSTART:    rd_data = {8'b0, sh_tstart_q};
      A_TEND:      rd_data = {8'b0, sh_tend_q};
      A_RSTART:    rd_data = {8'b0, sh_rstart_q};
      A_REND:      rd_data = {8'b0, sh_rend_q};
      default:     ;
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (ch_ok && int'(ch_idx) == c) begin
        case (ch_reg)
          R_EN:    rd_data = {30'b0, oen_q[c], ien_q[c]};
          R_IBASE: rd_data = ibase_q[c];
          R_ISIZE: rd_data = {8'b0, isize_q[c], 6'b0};
          R_OBASE: rd_data = obase_q[c];
          R_OSIZE: rd_data = {8'b0, osize_q[c], 6'b0};
          R_IACNT: rd_data = {8'b0, iacnt_i[18*c +: 18], 6'b0};
          R_OACNT: rd_data = {8'b0, oacnt_i[18*c +: 18], 6'b0};
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      tddmode_q        <= 1'b0;
      test_q           <= 1'b1;
      commit_pending_q <= 1'b0;
      adj_pending_q    <= 1'b0;
      adj_valid_q      <= 1'b0;
      irq_stat_q       <= '0;
      irq_mask_q       <= '0;
      irq_q            <= 1'b0;
      frame_cnt_q      <= '0;
      {sh_len_q, frame_len_q}   <= {LEN_RST, LEN_RST};
      {sh_tend_q, tend_q}       <= {END_RST, END_RST};
      {sh_rend_q, rend_q}       <= {END_RST, END_RST};
      {sh_tstart_q, tstart_q}   <= '0;
      {sh_rstart_q, rstart_q}   <= '0;
      frame_adj_q      <= '0;
      dout_q           <= '0;
      dout_vld_q       <= 1'b0;
      // NOTE: the channel arrays are small flop banks with defined power-up values, so they are reset.
      for (int c = 0; c < NCH; c++) begin
        ien_q[c]   <= 1'b0;
        oen_q[c]   <= 1'b0;
        ibase_q[c] <= 32'hFFFC_0000;
        obase_q[c] <= 32'hFFFC_0000;
        isize_q[c] <= 18'h400;
        osize_q[c] <= 18'h400;
      end
    end else begin
      if (wr) begin
        case (off)
          A_CTRL:      {test_q, tddmode_q} <= din_i[1:0];
          A_IRQ_MASK:  irq_mask_q  <= din_i[8:0];
          A_FRAME_LEN: sh_len_q    <= din_i[23:0];
          A_FRAME_ADJ: frame_adj_q <= din_i[23:0];
          A_TSTART:    sh_tstart_q <= din_i[23:0];
          A_TEND:      sh_tend_q   <= din_i[23:0];
          A_RSTART:    sh_rstart_q <= din_i[23:0];
          A_REND:      sh_rend_q   <= din_i[23:0];
          default:     ;
        endcase
        for (int c = 0; c < NCH; c++) begin
          if (ch_ok && int'(ch_idx) == c) begin
            case (ch_reg)
              R_EN:    {oen_q[c], ien_q[c]} <= din_i[1:0];
              R_IBASE: ibase_q[c] <= din_i;
              R_ISIZE: isize_q[c] <= din_i[23:6];
              R_OBASE: obase_q[c] <= din_i;
              R_OSIZE: osize_q[c] <= din_i[23:6];
              default: ;
            endcase
          end
        end
      end
      // Active values take the shadow as it stood before any same-cycle write.
      if (commit_fire) begin
        frame_len_q <= sh_len_q;
        tstart_q    <= sh_tstart_q;
        tend_q      <= sh_tend_q;
        rstart_q    <= sh_rstart_q;
        rend_q      <= sh_rend_q;
      end
      commit_pending_q <= commit_pending_d;
      adj_pending_q    <= adj_pending_d;
      adj_valid_q      <= adj_fire;
      irq_stat_q       <= irq_stat_d;
      irq_q            <= |(irq_stat_q & irq_mask_q);
      frame_cnt_q      <= frame_cnt_d;
      dout_q           <= rd ? rd_data : 32'h0;
      dout_vld_q       <= rd;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch_out
    assign ien_o[c]              = ien_q[c];
    assign oen_o[c]              = oen_q[c];
    assign ibase_o[32*c +: 32]   = ibase_q[c];
    assign obase_o[32*c +: 32]   = obase_q[c];
    assign isize_o[18*c +: 18]   = isize_q[c];
    assign osize_o[18*c +: 18]   = osize_q[c];
  end

  assign tddmode_o        = tddmode_q;
  assign test_o           = test_q;
  assign frame_len_o      = frame_len_q;
  assign tstart_o         = tstart_q;
  assign tend_o           = tend_q;
  assign rstart_o         = rstart_q;
  assign rend_o           = rend_q;
  assign frame_adj_o      = frame_adj_q;
  assign adj_valid_o      = adj_valid_q;
  assign adj_pending_o    = adj_pending_q;
  assign commit_pending_o = commit_pending_q;
  assign irq_o            = irq_q;
  assign dout_o           = dout_q;
  assign dout_vld_o       = dout_vld_q;

endmodule

// File: tb/tb_axi2sreg_mc.sv
// Directed bench for axi2sreg_mc: a register-access vector table plus hand-written
// sequences for commit, frame adjust, interrupt and frame-counter corner cases.
module tb_axi2sreg_mc;
  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0, wen = 1'b0;
  logic [17:0]       addr = '0;
  logic [31:0]       din = '0;
  logic [31:0]       dout;
  logic              dout_vld;
  logic              frame_sync = 1'b0;
  logic [NCH-1:0]    ierr = '0, oerr = '0;
  logic [18*NCH-1:0] iacnt = '0, oacnt = '0;
  logic [NCH-1:0]    ien, oen;
  logic [32*NCH-1:0] ibase, obase;
  logic [18*NCH-1:0] isize, osize;
  logic              tddmode, test;
  logic [23:0]       frame_len, tstart, tend, rstart, rend, frame_adj;
  logic              adj_valid, adj_pending, commit_pending, irq;

  int n_checks = 0;
  int n_errors = 0;

  axi2sreg_mc #(.BASE(18'h0), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .en_i(en), .wen_i(wen), .addr_i(addr), .din_i(din),
    .dout_o(dout), .dout_vld_o(dout_vld), .frame_sync_i(frame_sync),
    .ierr_i(ierr), .oerr_i(oerr), .iacnt_i(iacnt), .oacnt_i(oacnt),
    .ien_o(ien), .oen_o(oen), .ibase_o(ibase), .obase_o(obase),
    .isize_o(isize), .osize_o(osize), .tddmode_o(tddmode), .test_o(test),
    .frame_len_o(frame_len), .tstart_o(tstart), .tend_o(tend), .rstart_o(rstart),
    .rend_o(rend), .frame_adj_o(frame_adj), .adj_valid_o(adj_valid),
    .adj_pending_o(adj_pending), .commit_pending_o(commit_pending), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          do_wr;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          exp_vld;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit w, input logic [17:0] a, input logic [31:0] d,
                     input logic [31:0] e, input bit v, input string n);
    vec_t t;
    t.do_wr = w; t.addr = a; t.wdata = d; t.exp = e; t.exp_vld = v; t.name = n;
    vecs.push_back(t);
  endtask

  task automatic bus_wr(input logic [17:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [17:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    en = 1'b1; wen = 1'b0; addr = a;
    @(negedge clk);
    en = 1'b0;
    d = dout; v = dout_vld;
  endtask

  task automatic rd_check(input string name, input logic [17:0] a, input logic [31:0] e);
    logic [31:0] d;
    logic v;
    bus_rd(a, d, v);
    check(name, {31'b0, v, d}, {31'b0, 1'b1, e});
  endtask

  task automatic wr_with_sync(input logic [17:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = a; din = d; frame_sync = 1'b1;
    @(negedge clk);
    en = 1'b0; wen = 1'b0; frame_sync = 1'b0;
  endtask

  task automatic pulse_sync();
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  initial begin
    logic [31:0] rdat;
    logic        rvld;

    add(0, 18'h00, 0, 32'h2,         1, "rst_ctrl");
    add(0, 18'h04, 0, 32'h0,         1, "rst_commit");
    add(0, 18'h0C, 0, 32'h0,         1, "rst_irq_mask");
    add(0, 18'h10, 0, 32'h0,         1, "rst_frame_cnt");
    add(0, 18'h20, 0, 32'd1920,      1, "rst_sh_frame_len");
    add(0, 18'h34, 0, 32'd1919,      1, "rst_sh_tend");
    add(0, 18'h3C, 0, 32'd1919,      1, "rst_sh_rend");
    add(0, 18'h44, 0, 32'hFFFC0000,  1, "rst_ibase0");
    add(0, 18'h50, 0, 32'h00010000,  1, "rst_osize0");
    add(1, 18'h00, 32'h3,        32'h3,        1, "ctrl_rw");
    add(1, 18'h0C, 32'hFFFF,     32'h1FF,      1, "irq_mask_width");
    add(1, 18'h0C, 32'h0,        32'h0,        1, "irq_mask_clear");
    add(1, 18'h40, 32'h3,        32'h3,        1, "en0_rw");
    add(1, 18'h68, 32'hFFFFFFFF, 32'h00FFFFC0, 1, "isize1_bits");
    add(1, 18'h6C, 32'h12345678, 32'h12345678, 1, "obase1_rw");
    add(1, 18'h60, 32'h2,        32'h2,        1, "en1_rw");
    add(1, 18'h14, 32'hDEAD,     32'h0,        1, "unmapped_gap");
    add(1, 18'h80, 32'hFFFF,     32'h0,        1, "unmapped_ch2");
    add(1, 18'h100, 32'h0,       32'h0,        0, "base_miss");
    add(0, 18'h00, 0,            32'h3,        1, "ctrl_after_miss");
    add(1, 18'h30, 32'hABCDEF12, 32'h00CDEF12, 1, "tstart_width");
    add(1, 18'h30, 32'h0,        32'h0,        1, "tstart_restore");

    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_mode", {tddmode, test}, 2'b01);
    check("rst_en", {ien, oen}, '0);
    check("rst_bases", {ibase, obase}, {4{32'hFFFC0000}});
    check("rst_sizes", {isize, osize}, {4{18'h400}});
    check("rst_timing", {frame_len, tend, rend, tstart, rstart, frame_adj},
          {24'd1920, 24'd1919, 24'd1919, 24'd0, 24'd0, 24'd0});
    check("rst_flags", {adj_valid, adj_pending, commit_pending, irq, dout_vld, dout},
          {5'b0, 32'h0});

    foreach (vecs[i]) begin
      if (vecs[i].do_wr) bus_wr(vecs[i].addr, vecs[i].wdata);
      bus_rd(vecs[i].addr, rdat, rvld);
      check(vecs[i].name, {31'b0, rvld, rdat}, {31'b0, vecs[i].exp_vld, vecs[i].exp});
    end
    check("outputs_after_table", {tddmode, test, ien, oen}, {1'b1, 1'b1, 2'b01, 2'b11});
    check("obase1_out", obase[63:32], 32'h12345678);
    check("isize1_out", isize[35:18], 18'h3FFFF);

    // Read data is valid for one cycle only.
    rd_check("rdlat_ctrl", 18'h00, 32'h3);
    @(negedge clk);
    check("rdlat_idle", {dout_vld, dout}, 33'h0);

    // Commit path: active holds until an armed frame_sync.
    bus_wr(18'h20, 32'd3840);
    check("commit_hold_pre", frame_len, 24'd1920);
    bus_wr(18'h04, 32'h1);
    check("commit_armed", {commit_pending, frame_len}, {1'b1, 24'd1920});
    pulse_sync();
    check("commit_applied", {commit_pending, frame_len}, {1'b0, 24'd3840});
    rd_check("irq_stat_commit", 18'h08, 32'h100);
    bus_wr(18'h08, 32'h100);
    rd_check("irq_stat_w1c", 18'h08, 32'h0);

    // Arm coincident with sync: commit waits for the next sync.
    bus_wr(18'h20, 32'd1000);
    wr_with_sync(18'h04, 32'h1);
    check("arm_at_sync", {commit_pending, frame_len}, {1'b1, 24'd3840});
    pulse_sync();
    check("arm_next_sync", {commit_pending, frame_len}, {1'b0, 24'd1000});

    // Shadow write in the commit cycle: active takes the old shadow.
    bus_wr(18'h30, 32'd5);
    bus_wr(18'h04, 32'h1);
    wr_with_sync(18'h30, 32'd77);
    check("commit_pre_write", tstart, 24'd5);
    rd_check("shadow_keeps_new", 18'h30, 32'd77);
    bus_wr(18'h08, 32'h1FF);
    rd_check("irq_stat_cleared", 18'h08, 32'h0);

    // Frame adjust: one-cycle valid at the next sync.
    bus_wr(18'h24, 32'h10);
    check("adj_loaded", {adj_pending, adj_valid, frame_adj}, {2'b10, 24'h10});
    pulse_sync();
    check("adj_valid_hi", {adj_valid, adj_pending}, 2'b10);
    @(negedge clk);
    check("adj_valid_lo", adj_valid, 1'b0);
    rd_check("commit_rd_adj_clr", 18'h04, 32'h0);
    wr_with_sync(18'h24, 32'h20);
    check("adj_wr_at_sync", {adj_pending, adj_valid, frame_adj}, {2'b10, 24'h20});
    pulse_sync();
    check("adj_after_sync", {adj_valid, adj_pending}, 2'b10);

    // Interrupts: sticky status, masking, set beats W1C.
    bus_wr(18'h0C, 32'h2);
    @(negedge clk);
    ierr = 2'b10;
    @(negedge clk);
    ierr = 2'b00;
    @(negedge clk);
    check("irq_asserted", irq, 1'b1);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = 18'h08; din = 32'h2; ierr = 2'b10;
    @(negedge clk);
    en = 1'b0; wen = 1'b0; ierr = 2'b00;
    rd_check("set_beats_clear", 18'h08, 32'h2);
    bus_wr(18'h08, 32'h2);
    rd_check("w1c_ierr1", 18'h08, 32'h0);
    check("irq_deasserted", irq, 1'b0);
    @(negedge clk);
    oerr = 2'b01;
    @(negedge clk);
    oerr = 2'b00;
    rd_check("oerr0_bit4", 18'h08, 32'h10);
    check("irq_masked", irq, 1'b0);
    bus_wr(18'h08, 32'h10);

    // Address counter readback.
    iacnt = {18'h3FFFF, 18'h00001};
    oacnt = {18'h12345, 18'h00000};
    rd_check("iacnt1", 18'h74, 32'h00FFFFC0);
    @(negedge clk);
    check("iacnt1_vld_drop", {dout_vld, dout}, 33'h0);
    rd_check("iacnt0", 18'h54, 32'h00000040);
    rd_check("oacnt1", 18'h78, 32'h0048D140);
    rd_check("ch2_unmapped", 18'h80, 32'h0);

    // Reset mid-operation discards pending commit/adjust.
    bus_wr(18'h20, 32'd500);
    bus_wr(18'h04, 32'h1);
    bus_wr(18'h24, 32'h5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_flags", {commit_pending, adj_pending, tddmode, test}, 4'b0001);
    pulse_sync();
    check("rst_mid_no_fire", {adj_valid, frame_len, frame_adj}, {1'b0, 24'd1920, 24'd0});

    // Frame counter and wrap.
    rd_check("frame_cnt_one", 18'h10, 32'd1);
    @(negedge clk);
    force dut.frame_cnt_d = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.frame_cnt_d;
    rd_check("frame_cnt_preload", 18'h10, 32'hFFFFFFFF);
    pulse_sync();
    rd_check("frame_cnt_wrap", 18'h10, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi2sreg_mc.md
AXI2SREG_MC -- requirements
Module: axi2sreg_mc

Interface
REQ-001 Parameter BASE, 18'h0, register block base; decode hit when addr[17:8]==BASE[17:8].
REQ-002 Parameter NCH, 2, stream channel count, legal 1..4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en / wen  in  1 / 1  bus access strobe / write qualifier.
REQ-006 addr / din  in  18 / 32  byte address / write data.
REQ-007 dout / dout_vld  out  32 / 1  registered read data / read-data-valid.
REQ-008 frame_sync  in  1  one-cycle frame-boundary pulse.
REQ-009 ierr, oerr  in  NCH each  per-channel AXI error pulses.
REQ-010 iacnt, oacnt  in  18*NCH each  per-channel address counters [23:6], channel c at bits [18c+17:18c].
REQ-011 ien, oen  out  NCH each; ibase, obase  out  32*NCH; isize, osize  out  18*NCH.
REQ-012 tddmode, test  out  1 each  global mode bits.
REQ-013 frame_len, tstart, tend, rstart, rend, frame_adj  out  24 each  active timing values.
REQ-014 adj_valid / adj_pending / commit_pending / irq  out  1 each.

Function
REQ-015 Write occurs when en&wen&hit; read occurs when en&!wen&hit; unmapped offsets ignore writes and read 0.
REQ-016 Read latency 1 cycle: dout and dout_vld=1 in the cycle after the read; otherwise dout=0, dout_vld=0.
REQ-017 Global map: 0x00 CTRL RW {bit1 test, bit0 tddmode}; 0x04 COMMIT; 0x08 IRQ_STAT; 0x0C IRQ_MASK RW [8:0]; 0x10 FRAME_CNT RO.
REQ-018 Timing shadows RW [23:0]: 0x20 FRAME_LEN, 0x24 FRAME_ADJ, 0x30 TSTART, 0x34 TEND, 0x38 RSTART, 0x3C REND; reads return shadow.
REQ-019 Channel c (c<NCH) at 0x40+0x20*c: +0x00 EN {bit1 oen, bit0 ien}, +0x04 IBASE, +0x08 ISIZE din[23:6], +0x0C OBASE, +0x10 OSIZE din[23:6], +0x14 IACNT RO, +0x18 OACNT RO.
REQ-020 ISIZE/OSIZE/IACNT/OACNT read back at bits [23:6], other bits 0; channel blocks with c>=NCH are unmapped.
REQ-021 EN, bases, sizes, CTRL drive outputs directly, updated the cycle after the write.
REQ-022 Write COMMIT with din[0]=1 sets commit_pending; on frame_sync with commit_pending already 1, shadows FRAME_LEN/TSTART/TEND/RSTART/REND copy to active outputs, commit_pending clears, IRQ_STAT[8] sets.
REQ-023 Arm and frame_sync in the same cycle: no commit at that sync; commit occurs at the next sync.
REQ-024 Shadow write in the commit cycle: active takes the pre-write shadow; the new value stays in shadow.
REQ-025 Write to FRAME_ADJ loads frame_adj output immediately and sets adj_pending; next frame_sync with adj_pending=1 gives adj_valid=1 for exactly one cycle and clears adj_pending.
REQ-026 FRAME_ADJ write in the same cycle as frame_sync: value loads, adj_pending stays 1, no adj_valid.
REQ-027 COMMIT read: bit0 commit_pending, bit1 adj_pending, others 0.
REQ-028 IRQ_STAT sticky: bit c set by ierr[c], bit 4+c set by oerr[c], bit8 by commit; write-1-to-clear; set event beats clear in the same cycle.
REQ-029 irq = |(IRQ_STAT & IRQ_MASK), registered, valid the cycle after the status change.
REQ-030 FRAME_CNT increments on each frame_sync, 32-bit, wraps 0xFFFFFFFF->0.

Reset
REQ-031 On rst: tddmode=0, test=1, ien=oen=0, every ibase/obase=32'hFFFC0000, every isize/osize=18'h400.
REQ-032 On rst: active and shadow frame_len=1920, tend=rend=1919, tstart=rstart=0; frame_adj=0.
REQ-033 On rst: commit_pending=adj_pending=adj_valid=0, IRQ_STAT=IRQ_MASK=0, irq=0, FRAME_CNT=0, dout=0, dout_vld=0.
REQ-034 Reset asserted mid-operation discards pending commit/adjust; no adj_valid or commit follows reset release.

Verification
REQ-035 Write FRAME_LEN=3840, COMMIT=1, pulse frame_sync -> frame_len stays 1920 until sync, then 3840; IRQ_STAT[8]=1.
REQ-036 COMMIT write coincident with frame_sync -> no change; second sync -> active updates.
REQ-037 FRAME_ADJ=0x10, frame_sync -> adj_valid high exactly 1 cycle, COMMIT read bit1 = 0.
REQ-038 ierr[1] pulse, IRQ_MASK=0x2 -> irq=1; W1C 0x2 with simultaneous ierr[1] -> bit stays 1.
REQ-039 NCH=2: read 0x60+0x14 with iacnt ch1=18'h3FFFF -> dout=0x00FFFFC0, dout_vld next cycle; read 0x80 -> 0.
REQ-040 2^32 frame_sync pulses (forced preload 0xFFFFFFFF) -> FRAME_CNT reads 0.
